// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Multi-cycle multiply/divide unit with HI/LO result registers, MIPS-style.
// A MULT/MULTU/DIV/DIVU issue latches its operands and holds Busy for a fixed
// number of cycles. The result is written to HI/LO only at the edge where
// Busy falls. MTHI/MTLO write A straight into HI/LO in a single cycle and
// never raise Busy.
//
// Parameters
//   MULT_CYCLES  Busy cycles for MULT/MULTU (must be >= 1)
//   DIV_CYCLES   Busy cycles for DIV/DIVU   (must be >= 1)
//
// Ports
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous active-high reset
//   A      in  32   rs operand: multiplicand, dividend or MTHI/MTLO data
//   B      in  32   rt operand: multiplier or divisor
//   MDUOp  in   3   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//   Start  in   1   issue strobe; MDUOp/A/B are sampled when Start=1
//   Busy   out  1   high while a multiply or divide is in flight (registered)
//   HI     out 32   HI register
//   LO     out 32   LO register
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready; accepts issues and MTHI/MTLO
// RUN    | mult/div in flight; counter runs down, Start is ignored
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    // Result datapath, evaluated from the latched operands only so that
    // input changes after issue cannot leak into the result.
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        div_b;
    logic               div_ovf;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'd0, a_q} * {32'd0, b_q};

        // A zero divisor never writes back; substituting 1 keeps the divider
        // free of divide-by-zero X propagation in simulation.
        div_b   = (b_q == 32'd0) ? 32'd1 : b_q;
        // The most-negative / -1 case overflows a 32-bit signed quotient;
        // pin it to the architecturally defined answer.
        div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

        if (div_ovf) begin
            quot_s = 32'h8000_0000;
            rem_s  = 32'd0;
        end else begin
            quot_s = $signed(a_q) / $signed(div_b);
            rem_s  = $signed(a_q) % $signed(div_b);
        end
        quot_u = a_q / div_b;
        rem_u  = a_q % div_b;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (MDUOp)
                        OP_MULT, OP_MULTU: begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            op_d    = MDUOp;
                            a_d     = A;
                            b_d     = B;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            op_d    = MDUOp;
                            a_d     = A;
                            b_d     = B;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    case (op_q)
                        OP_MULT: begin
                            hi_d = prod_s[63:32];
                            lo_d = prod_s[31:0];
                        end
                        OP_MULTU: begin
                            hi_d = prod_u[63:32];
                            lo_d = prod_u[31:0];
                        end
                        OP_DIV: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem_s;
                                lo_d = quot_s;
                            end
                        end
                        OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem_u;
                                lo_d = quot_u;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Busy is its own flop, loaded from the next state, so the output
        // has no combinational path from Start.
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, giving the number of Busy cycles for MULT/MULTU.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, giving the number of Busy cycles for DIV/DIVU.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit, the system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port A, input, 32 bits, rs operand: multiplicand, dividend, or MTHI/MTLO data.
REQ-007 The block SHALL have port B, input, 32 bits, rt operand: multiplier or divisor.
REQ-008 The block SHALL have port MDUOp, input, 3 bits, operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
REQ-009 The block SHALL have port Start, input, 1 bit, issue strobe; MDUOp and A/B are sampled at an edge where Start=1.
REQ-010 The block SHALL have port Busy, output, 1 bit, high while a multiply or divide is in progress.
REQ-011 The block SHALL have port HI, output, 32 bits, current HI register.
REQ-012 The block SHALL have port LO, output, 32 bits, current LO register.

Function
REQ-013 On an edge where Start=1, Busy=0 and MDUOp is 1-4, the block SHALL latch A, B and MDUOp internally and load the cycle counter.
REQ-014 After a MULT/MULTU issue at edge T, Busy SHALL be 1 for exactly MULT_CYCLES cycles starting after edge T; HI/LO SHALL update at the edge where Busy falls.
REQ-015 After a DIV/DIVU issue, Busy SHALL follow the same rule with DIV_CYCLES cycles.
REQ-016 During Busy, HI and LO SHALL hold their previous values; intermediate results SHALL NOT be visible.
REQ-017 MULT SHALL compute the signed 64-bit product of the latched operands: HI = bits 63:32, LO = bits 31:0.
REQ-018 MULTU SHALL compute the same as MULT with unsigned operands.
REQ-019 DIV SHALL produce LO = quotient and HI = remainder: signed, quotient truncated toward zero, remainder taking the dividend's sign.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-021 DIVU SHALL produce LO = quotient and HI = remainder, unsigned.
REQ-022 For DIV/DIVU with a latched divisor of 0, the operation SHALL still run DIV_CYCLES cycles with Busy, and HI/LO SHALL remain unchanged at completion.
REQ-023 With Start=1 and MDUOp=5 (MTHI) while Busy=0, HI SHALL take A at that edge, with no Busy cycle; LO is unchanged.
REQ-024 With Start=1 and MDUOp=6 (MTLO) while Busy=0, LO SHALL take A at that edge, with no Busy cycle; HI is unchanged.
REQ-025 Start=1 while Busy=1 SHALL be ignored for any MDUOp; the operation in flight and its latched operands are unaffected.
REQ-026 Start=1 with MDUOp of 0 or 7 SHALL have no effect.
REQ-027 Changes on A/B/MDUOp after issue SHALL NOT affect the result.
REQ-028 Busy SHALL be driven directly from a register, with no combinational path from Start.
REQ-029 Back-to-back operation: an issue is accepted at the same edge where Busy falls to 0 only if Busy was 0 before that edge; otherwise it is ignored per REQ-025.
REQ-030 The FSM SHALL have states IDLE and RUN.
REQ-031 FSM transition IDLE->RUN on a mult/div issue; RUN->IDLE when the counter reaches 1, with HI/LO written on that edge.

Reset
REQ-032 Reset=1 at an edge SHALL force HI=0, LO=0, Busy=0, state IDLE and counter=0, with priority over Start.
REQ-033 A reset during RUN SHALL discard the pending result, and no HI/LO write SHALL occur afterwards.

Verification
REQ-034 MULT with A=0xFFFFFFFE (-2), B=3, issued at edge T -> Busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-035 MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 DIV with A=0xFFFFFFF9 (-7), B=2 -> Busy=1 for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-037 DIVU with A=7, B=0, after a prior MTHI 0x1234 and MTLO 0x5678 -> HI=0x1234 and LO=0x5678 after Busy drops.
REQ-038 MULT A=2, B=3 issued, then MTLO A=9 issued 2 cycles later while Busy -> MTLO ignored; final LO=6, HI=0.
REQ-039 DIV issued, then reset asserted on the 4th Busy cycle -> next cycle Busy=0, HI=LO=0, and no later HI/LO update.
